inst_fetch_stage: RTL and testbench

- Instruction-fetch front end of the single-issue RV32I core.
- Sits directly upstream of the main control decoder: drives the PC to instruction memory over a request/acknowledge handshake and buffers returned words in a small FIFO.
- Presents one instruction per cycle with valid/ready to decode; Opcode (Inst[6:0]) feeds the control decoder directly.
- Handles branch/jump redirect with flush and discard of in-flight responses.

---
 rtl/rv_pkg.sv | 19 +
 rtl/inst_fifo.sv | 53 +++++
 rtl/inst_fetch_stage.sv | 127 ++++++++++++
 tb/tb_inst_fetch_stage.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared RV32I constants and fetch FSM encoding
package rv_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_WAIT = 2'd1,
        FS_DROP = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/inst_fifo.sv
// rtl/inst_fifo.sv - synchronous instruction buffer with flush, power-of-two depth
module inst_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Flush wins over push; a pop in the flush cycle has already been consumed downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop && !flush));

endmodule

// File: rtl/inst_fetch_stage.sv
// rtl/inst_fetch_stage.sv - RV32I fetch front end; IF_PERF_CNT_EN adds FetchCnt/StallCnt
module inst_fetch_stage #(
    parameter int              XLEN       = rv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            Clk,
    input  logic            Rst_n,
    output logic            IMemReq,
    output logic [XLEN-1:0] IMemAddr,
    input  logic            IMemAck,
    input  logic [31:0]     IMemRdata,
    input  logic            Redirect,
    input  logic [XLEN-1:0] RedirectPC,
    input  logic            InstReady,
    output logic            InstValid,
    output logic [31:0]     Inst,
    output logic [XLEN-1:0] InstPC,
`ifdef IF_PERF_CNT_EN
    output logic [31:0]     FetchCnt,
    output logic [31:0]     StallCnt,
`endif
    output logic [6:0]      Opcode
);
    import rv_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e    state;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] req_pc;
    logic [XLEN-1:0] redirect_target;
    logic [CW-1:0]   count;
    logic [CW:0]     occ_next;
    logic            full;
    logic            empty;
    logic            pop;
    logic            push;
    logic            has_space;
    logic [XLEN+31:0] head;

    assign pop             = !empty && InstReady;
    assign push            = (state == FS_WAIT) && IMemAck && !Redirect;
    assign redirect_target = RedirectPC & ~XLEN'(3);

    // Occupancy after this cycle's pop/push; one more slot must be free for a new request.
    assign occ_next  = {1'b0, count} - (CW+1)'(pop) + (CW+1)'(push);
    assign has_space = (int'(occ_next) + 1) <= FIFO_DEPTH;

    inst_fifo #(
        .WIDTH (XLEN + 32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (Clk),
        .rst_n     (Rst_n),
        .push      (push),
        .push_data ({req_pc, IMemRdata}),
        .pop       (pop),
        .flush     (Redirect),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .head      (head)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= FS_IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
            IMemReq  <= 1'b0;
            IMemAddr <= RESET_PC;
        end else begin
            IMemReq <= 1'b0;
            if (Redirect) begin
                fetch_pc <= redirect_target;
                // A response still in flight must be swallowed before fetching again.
                state    <= (state != FS_IDLE && !IMemAck) ? FS_DROP : FS_IDLE;
            end else begin
                case (state)
                    FS_IDLE: begin
                        if (has_space) begin
                            IMemReq  <= 1'b1;
                            IMemAddr <= fetch_pc;
                            req_pc   <= fetch_pc;
                            state    <= FS_WAIT;
                        end
                    end
                    FS_WAIT: begin
                        if (IMemAck) begin
                            fetch_pc <= fetch_pc + XLEN'(4);
                            if (has_space) begin
                                IMemReq  <= 1'b1;
                                IMemAddr <= fetch_pc + XLEN'(4);
                                req_pc   <= fetch_pc + XLEN'(4);
                            end else begin
                                state <= FS_IDLE;
                            end
                        end
                    end
                    FS_DROP: begin
                        if (IMemAck) state <= FS_IDLE;
                    end
                    default: state <= FS_IDLE;
                endcase
            end
        end
    end

    assign InstValid = !empty;
    assign Inst      = empty ? INST_NOP : head[31:0];
    assign InstPC    = empty ? '0 : head[XLEN+31:32];
    assign Opcode    = Inst[6:0];

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            FetchCnt <= '0;
            StallCnt <= '0;
        end else begin
            FetchCnt <= FetchCnt + 32'(push);
            StallCnt <= StallCnt + 32'(!empty && !InstReady);
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch_stage.sv
// tb/tb_inst_fetch_stage.sv - randomized fetch-stage bench against a transaction-level model
module tb_inst_fetch_stage;

    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemAck = 1'b0;
    logic [31:0] IMemRdata = '0;
    logic        Redirect = 1'b0;
    logic [31:0] RedirectPC = '0;
    logic        InstReady = 1'b0;
    logic        InstValid;
    logic [31:0] Inst;
    logic [31:0] InstPC;
    logic [6:0]  Opcode;
`ifdef IF_PERF_CNT_EN
    logic [31:0] FetchCnt;
    logic [31:0] StallCnt;
`endif

    always #5 Clk = ~Clk;

    inst_fetch_stage #(
        .XLEN       (32),
        .RESET_PC   (32'h0),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .IMemReq    (IMemReq),
        .IMemAddr   (IMemAddr),
        .IMemAck    (IMemAck),
        .IMemRdata  (IMemRdata),
        .Redirect   (Redirect),
        .RedirectPC (RedirectPC),
        .InstReady  (InstReady),
        .InstValid  (InstValid),
        .Inst       (Inst),
        .InstPC     (InstPC),
`ifdef IF_PERF_CNT_EN
        .FetchCnt   (FetchCnt),
        .StallCnt   (StallCnt),
`endif
        .Opcode     (Opcode)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } ent_t;

    ent_t        q[$];
    logic [31:0] next_addr;
    logic [31:0] out_word;
    logic [31:0] fetch_cnt_m;
    logic [31:0] stall_cnt_m;
    logic [31:0] word_seq[$];
    logic [31:0] word_tbl[5];
    bit          outst;
    bit          stale;
    bit          exp_req;
    int          out_age;
    int          out_lat;

    int          lat_min   = 1;
    int          lat_max   = 1;
    int          ready_pct = 100;
    int          redir_pct = 0;
    int          redir_mode = 0;
    logic [31:0] redir_target;

    function automatic logic [31:0] pick_word();
        logic [31:0] w;
        if (word_seq.size() > 0) w = word_seq.pop_front();
        else if ($urandom_range(0, 1) == 1) w = word_tbl[$urandom_range(0, 4)];
        else w = $urandom;
        return w;
    endfunction

    task automatic check_outputs();
        ent_t h;
        bit   have;
        have = q.size() > 0;
        h    = have ? q[0] : '{pc: 32'h0, word: NOP};
        expect_eq("inst_valid", InstValid, 32'(have));
        expect_eq("inst", Inst, h.word);
        expect_eq("inst_pc", InstPC, h.pc);
        expect_eq("opcode", Opcode, {25'h0, h.word[6:0]});
        expect_eq("imem_req", IMemReq, 32'(exp_req));
`ifdef IF_PERF_CNT_EN
        expect_eq("fetch_cnt", FetchCnt, fetch_cnt_m);
        expect_eq("stall_cnt", StallCnt, stall_cnt_m);
`endif
    endtask

    task automatic step();
        bit          ack;
        bit          redir;
        bit          rdy;
        bit          pop;
        bit          push;
        bit          may_issue;
        logic [31:0] tgt;
        @(negedge Clk);
        check_outputs();
        if (IMemReq) begin
            expect_eq("imem_addr", IMemAddr, next_addr);
            outst    = 1'b1;
            stale    = 1'b0;
            out_age  = 0;
            out_lat  = $urandom_range(lat_min, lat_max);
            out_word = pick_word();
        end else if (outst) begin
            out_age++;
        end
        ack = outst && (out_age == out_lat);
        tgt = $urandom;
        redir = ($urandom_range(0, 99) < redir_pct);
        if ((redir_mode == 1 && outst && !ack && !stale) ||
            (redir_mode == 2 && ack && !stale) || redir_mode == 3) begin
            redir      = 1'b1;
            tgt        = redir_target;
            redir_mode = 0;
        end
        rdy = ($urandom_range(0, 99) < ready_pct);

        IMemAck    = ack;
        IMemRdata  = ack ? out_word : $urandom;
        Redirect   = redir;
        RedirectPC = tgt;
        InstReady  = rdy;

        pop       = (q.size() > 0) && rdy;
        push      = ack && !stale && !redir;
        may_issue = !outst || (ack && !stale);
        if (q.size() > 0 && !rdy) stall_cnt_m++;
        if (pop) void'(q.pop_front());
        if (push) begin
            q.push_back('{pc: next_addr, word: out_word});
            next_addr += 32'd4;
            fetch_cnt_m++;
        end
        if (ack) outst = 1'b0;
        if (redir) begin
            q.delete();
            next_addr = {tgt[31:2], 2'b00};
            if (outst) stale = 1'b1;
        end
        exp_req = !redir && may_issue && (q.size() + 1 <= DEPTH);
    endtask

    // Called at a negedge: the stale ack driven here lands on an idle FSM and must be ignored.
    task automatic release_reset();
        Rst_n       = 1'b1;
        IMemAck     = 1'b1;
        IMemRdata   = $urandom;
        Redirect    = 1'b0;
        InstReady   = 1'b1;
        q.delete();
        outst       = 1'b0;
        stale       = 1'b0;
        next_addr   = 32'h0;
        fetch_cnt_m = '0;
        stall_cnt_m = '0;
        exp_req     = 1'b1;
    endtask

    task automatic check_reset_values();
        expect_eq("rst_imem_req", IMemReq, 32'h0);
        expect_eq("rst_imem_addr", IMemAddr, 32'h0);
        expect_eq("rst_inst_valid", InstValid, 32'h0);
        expect_eq("rst_inst", Inst, NOP);
        expect_eq("rst_inst_pc", InstPC, 32'h0);
        expect_eq("rst_opcode", Opcode, 32'h13);
`ifdef IF_PERF_CNT_EN
        expect_eq("rst_fetch_cnt", FetchCnt, 32'h0);
        expect_eq("rst_stall_cnt", StallCnt, 32'h0);
`endif
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int waited;
        word_tbl[0] = 32'h00A0_0093;
        word_tbl[1] = 32'h0000_0033;
        word_tbl[2] = 32'h0000_2003;
        word_tbl[3] = 32'h0000_2023;
        word_tbl[4] = 32'h0000_0063;

        repeat (3) @(negedge Clk);
        check_reset_values();
        release_reset();

        // streaming, ack latency 1, decode always ready
        lat_min = 1; lat_max = 1; ready_pct = 100; redir_pct = 0;
        run(16);

        // decode stalls: FIFO fills, requests stop, then drain in order
        ready_pct = 0;
        word_seq.push_back(32'h00A0_0093);
        word_seq.push_back(32'h0000_0033);
        run(10);
        ready_pct = 100;
        run(10);

        // redirect while waiting on a slow ack
        lat_min = 3; lat_max = 3;
        redir_mode = 1; redir_target = 32'h0000_0100;
        run(20);

        // redirect coincident with ack
        lat_min = 1; lat_max = 2;
        redir_mode = 2; redir_target = 32'h0000_0200;
        run(20);

        // misaligned target and PC wrap
        redir_mode = 3; redir_target = 32'h0000_0103;
        run(10);
        redir_mode = 3; redir_target = 32'hFFFF_FFF9;
        run(12);

        // random soak
        lat_min = 1; lat_max = 4; ready_pct = 60; redir_pct = 5;
        run(2000);

        // asynchronous reset while a request is outstanding
        redir_pct = 0; lat_min = 3; lat_max = 3; ready_pct = 0;
        waited = 0;
        while (!(outst && out_age == 0) && waited < 20) begin
            step();
            waited++;
        end
        expect_eq("reach_wait", 32'(outst), 32'h1);
        @(posedge Clk);
        #2;
        Rst_n = 1'b0;
        #1;
        check_reset_values();
        @(negedge Clk);
        IMemAck = 1'b1;
        @(negedge Clk);
        check_reset_values();
        release_reset();

        lat_min = 1; lat_max = 4; ready_pct = 70; redir_pct = 3;
        run(300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
